// File: rtl/platformer_pkg.sv
// Shared definitions for the platformer: game state encodings, seven-segment
// codes and the BCD digit correction used by the score display.
package platformer_pkg;

   typedef enum logic [2:0] {
      S_RUNNING   = 3'd0,
      S_GAME_OVER = 3'd1,
      S_WIN       = 3'd2
   } game_state_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      LOAD    = 2'd2
   } conv_state_e;

   localparam int TICK_HZ = 60;

   // Active-low segments, bit0 = a .. bit6 = g.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   // Double-dabble correction applied to every nibble before each shift.
   function automatic logic [15:0] dabble_word(input logic [15:0] bcd);
      logic [15:0] r;
      r = bcd;
      for (int i = 0; i < 4; i++) begin
         if (r[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
module seven_seg_decoder
   import platformer_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/score_display.sv
// Samples the game score on game_tick, converts it to BCD one bit per clock
// and drives four blinking, leading-zero-blanked seven-segment digits.
module score_display
   import platformer_pkg::*;
#(
   parameter int          BLINK_TICKS        = 30,
   parameter bit          LEADING_ZERO_BLANK = 1'b1,
   parameter logic [15:0] MAX_SCORE          = 16'd9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        game_tick,
   input  logic [15:0] score,
   input  logic [2:0]  game_state,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic        busy,
   output logic        saturated
);

   localparam int            BW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [6:0]    SEG_LEAD   = LEADING_ZERO_BLANK ? SEG_BLANK : SEG_0;

   function automatic logic [15:0] sat_score(input logic [15:0] s);
      return (s > MAX_SCORE) ? MAX_SCORE : s;
   endfunction

   conv_state_e   state_q, state_d;
   logic [15:0]   operand_q, operand_d;
   logic [15:0]   bcd_work_q, bcd_work_d;
   logic [15:0]   bcd_q, bcd_d;
   logic [15:0]   last_score_q, last_score_d;
   logic [3:0]    shift_cnt_q, shift_cnt_d;
   logic          sat_pending_q, sat_pending_d;
   logic          busy_q, busy_d;
   logic          saturated_q, saturated_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blank_phase_q, blank_phase_d;
   logic          blink_active;
   logic [6:0]    digit_seg [4];
   logic [3:0]    lead_blank;
   logic [6:0]    hex_q [4];
   logic [6:0]    hex_d [4];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         operand_q     <= '0;
         bcd_work_q    <= '0;
         bcd_q         <= '0;
         last_score_q  <= '0;
         shift_cnt_q   <= '0;
         sat_pending_q <= 1'b0;
         busy_q        <= 1'b0;
         saturated_q   <= 1'b0;
         blink_cnt_q   <= '0;
         blank_phase_q <= 1'b0;
         hex_q[0]      <= SEG_0;
         hex_q[1]      <= SEG_LEAD;
         hex_q[2]      <= SEG_LEAD;
         hex_q[3]      <= SEG_LEAD;
      end else begin
         state_q       <= state_d;
         operand_q     <= operand_d;
         bcd_work_q    <= bcd_work_d;
         bcd_q         <= bcd_d;
         last_score_q  <= last_score_d;
         shift_cnt_q   <= shift_cnt_d;
         sat_pending_q <= sat_pending_d;
         busy_q        <= busy_d;
         saturated_q   <= saturated_d;
         blink_cnt_q   <= blink_cnt_d;
         blank_phase_q <= blank_phase_d;
         hex_q         <= hex_d;
      end
   end

   // Conversion FSM: capture, 16 dabble-and-shift iterations, load.
   always_comb begin
      state_d       = state_q;
      operand_d     = operand_q;
      bcd_work_d    = bcd_work_q;
      bcd_d         = bcd_q;
      last_score_d  = last_score_q;
      shift_cnt_d   = shift_cnt_q;
      sat_pending_d = sat_pending_q;
      busy_d        = busy_q;
      saturated_d   = saturated_q;
      case (state_q)
         IDLE: begin
            if (game_tick && (score != last_score_q)) begin
               operand_d     = sat_score(score);
               sat_pending_d = (score > MAX_SCORE);
               last_score_d  = score;
               shift_cnt_d   = '0;
               bcd_work_d    = '0;
               busy_d        = 1'b1;
               state_d       = CONVERT;
            end
         end
         CONVERT: begin
            {bcd_work_d, operand_d} = {dabble_word(bcd_work_q), operand_q} << 1;
            shift_cnt_d = shift_cnt_q + 4'd1;
            if (shift_cnt_q == 4'd15) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            bcd_d       = bcd_work_q;
            saturated_d = sat_pending_q;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign blink_active = (game_state == S_GAME_OVER) || (game_state == S_WIN);

   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blank_phase_d = blank_phase_q;
      if (!blink_active) begin
         blink_cnt_d   = '0;
         blank_phase_d = 1'b0;
      end else if (game_tick) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blank_phase_d = ~blank_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_dec
      seven_seg_decoder u_dec (
         .digit_i (bcd_d[4*g +: 4]),
         .seg_o   (digit_seg[g])
      );
   end

   // Segments are decoded from next-state values so the display lands on the LOAD edge.
   always_comb begin
      lead_blank    = '0;
      lead_blank[3] = LEADING_ZERO_BLANK && (bcd_d[15:12] == 4'd0);
      lead_blank[2] = lead_blank[3] && (bcd_d[11:8] == 4'd0);
      lead_blank[1] = lead_blank[2] && (bcd_d[7:4] == 4'd0);
      for (int i = 0; i < 4; i++) begin
         hex_d[i] = (blank_phase_d || lead_blank[i]) ? SEG_BLANK : digit_seg[i];
      end
   end

   assign HEX0      = hex_q[0];
   assign HEX1      = hex_q[1];
   assign HEX2      = hex_q[2];
   assign HEX3      = hex_q[3];
   assign busy      = busy_q;
   assign saturated = saturated_q;

endmodule
